// File: rtl/fx2fl_fsm_pkg.sv
// Shared constants for the fixed-point to FP32 converter:
// FSM state encodings and single-precision field layout.
package fx2fl_fsm_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ABS  = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_PACK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    function automatic logic [31:0] fp_pack(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [FRAC_W-1:0] f
    );
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fx2fl_fsm_if.sv
// Single-shot r_i/r_o request bus carrying the fixed-point
// operand in and the packed FP32 result out.
interface fx2fl_fsm_if;

    logic [31:0] num;
    logic        r_i;
    logic [31:0] res;
    logic        r_o;

    modport master (
        output num,
        output r_i,
        input  res,
        input  r_o
    );

    modport slave (
        input  num,
        input  r_i,
        output res,
        output r_o
    );

endinterface

// File: rtl/fx2fl_fsm_abs.sv
// Combinational sign/magnitude split of a 32-bit two's-complement word.
// The most negative value maps onto itself, which is the correct magnitude.
module fx_abs (
    input  logic [31:0] num,
    output logic        sign,
    output logic [31:0] mag
);

    assign sign = num[31];
    assign mag  = num[31] ? (~num + 32'd1) : num;

endmodule

// File: rtl/fx2fl_fsm.sv
// Multicycle signed fixed-point to IEEE-754 single converter.
// Normalises one bit per clock; truncates the fraction.
module fx2fl_fsm
    import fx2fl_fsm_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input logic        clk,
    input logic        rst,
    fx2fl_fsm_if.slave bus
);

    localparam logic [EXP_W-1:0] EXP_BASE = EXP_W'(BIAS + 31 - FRAC_BITS);

    logic [2:0]        state;
    logic [31:0]       num_q;
    logic [31:0]       mag;
    logic [4:0]        k;
    logic              sign;
    logic [31:0]       res_q;
    logic              abs_sign;
    logic [31:0]       abs_mag;
    logic [EXP_W-1:0]  exp_f;

    fx_abs u_abs (
        .num  (num_q),
        .sign (abs_sign),
        .mag  (abs_mag)
    );

    // 9-bit exponent truncated to 8 bits equals this modulo-256 difference
    assign exp_f = EXP_BASE - {3'd0, k};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            num_q <= '0;
            mag   <= '0;
            k     <= '0;
            sign  <= 1'b0;
            res_q <= ZERO;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.r_i) begin
                        num_q <= bus.num;
                        state <= S_ABS;
                    end
                end
                S_ABS: begin
                    sign  <= abs_sign;
                    mag   <= abs_mag;
                    k     <= '0;
                    state <= S_NORM;
                end
                // exits once the leading one reaches bit 31 (or value is zero)
                S_NORM: begin
                    if (mag == 32'd0 || mag[31]) begin
                        state <= S_PACK;
                    end else begin
                        mag <= mag << 1;
                        k   <= k + 5'd1;
                    end
                end
                S_PACK: begin
                    if (mag == 32'd0)
                        res_q <= ZERO;
                    else
                        res_q <= fp_pack(sign, exp_f, mag[30:8]);
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.r_o = (state == S_DONE);
    assign bus.res = res_q;

endmodule
